// File: rtl/fp_int_operand_feeder.sv
// Purpose: serialises a packed word of LANES signed ints plus one shared FP operand into (fp, int) pairs for the FP x INT multiplier.
// Latency: a word accepted on edge t presents lane 0 after edge t; throughput one lane per cycle, zero bubble between words.
// Backpressure: valid/ready; all outputs hold bit-stable while out_valid_o & !out_ready_i. Optional FP_INT_FEEDER_PERF_CNT_EN adds stall_cnt_o.
module fp_int_operand_feeder #(
    parameter int FP_WIDTH  = 16,
    parameter int INT_WIDTH = 4,
    parameter int LANES     = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [FP_WIDTH-1:0]        in_fp_i,
    input  logic [LANES*INT_WIDTH-1:0] in_int_i,
    input  logic                       in_last_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [FP_WIDTH-1:0]        out_fp_o,
    output logic [INT_WIDTH-1:0]       out_int_o,
    output logic                       out_lane_last_o,
    output logic                       out_group_last_o,
    output logic                       busy_o
`ifdef FP_INT_FEEDER_PERF_CNT_EN
    ,
    output logic [31:0]                stall_cnt_o
`endif
);

    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int WORD_W = LANES * INT_WIDTH;
    localparam logic [LANE_W-1:0] LANE_PENULT = LANE_W'(LANES - 2);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [LANE_W-1:0]   lane_q, lane_d;
    logic [FP_WIDTH-1:0] fp_q, fp_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic                word_last_q, word_last_d;
    logic                lane_last_q, lane_last_d;
    logic                group_last_q, group_last_d;

    // Handshake qualifiers shared by the FSM and the datapath.
    logic out_xfer;
    logic load_word;
    logic advance_lane;

    // State register; reset drops any held word at once.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake outputs. in_ready_o in STREAM is the
    // combinational out_ready_i path that lets the next word load on the
    // same edge the last lane leaves, so back-to-back words have no bubble.
    always_comb begin
        state_d      = state_q;
        in_ready_o   = 1'b0;
        out_valid_o  = 1'b0;
        busy_o       = 1'b0;
        out_xfer     = 1'b0;
        load_word    = 1'b0;
        advance_lane = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    load_word = 1'b1;
                    state_d   = ST_STREAM;
                end
            end
            ST_STREAM: begin
                out_valid_o = 1'b1;
                busy_o      = 1'b1;
                in_ready_o  = out_ready_i & lane_last_q;
                out_xfer    = out_ready_i;
                if (out_xfer && !lane_last_q) begin
                    advance_lane = 1'b1;
                end else if (out_xfer && in_valid_i) begin
                    load_word = 1'b1;
                end else if (out_xfer) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath next values. The word is kept in a shift register so the
    // current lane is always the low slice, and out_int_o is a plain flop
    // output rather than a lane-select mux in front of the multiplier.
    always_comb begin
        lane_d       = lane_q;
        fp_d         = fp_q;
        word_d       = word_q;
        word_last_d  = word_last_q;
        lane_last_d  = lane_last_q;
        group_last_d = group_last_q;
        if (load_word) begin
            lane_d       = '0;
            fp_d         = in_fp_i;
            word_d       = in_int_i;
            word_last_d  = in_last_i;
            lane_last_d  = 1'b0;
            group_last_d = 1'b0;
        end else if (advance_lane) begin
            lane_d       = lane_q + LANE_W'(1);
            word_d       = word_q >> INT_WIDTH;
            lane_last_d  = (lane_q == LANE_PENULT);
            group_last_d = (lane_q == LANE_PENULT) & word_last_q;
        end else if (out_xfer) begin
            // Final lane left with nothing queued behind it: clear the flags
            // so an idle feeder never advertises a stale end-of-group.
            lane_d       = '0;
            lane_last_d  = 1'b0;
            group_last_d = 1'b0;
        end
    end

    // Datapath registers; everything returns to zero on reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lane_q       <= '0;
            fp_q         <= '0;
            word_q       <= '0;
            word_last_q  <= 1'b0;
            lane_last_q  <= 1'b0;
            group_last_q <= 1'b0;
        end else begin
            lane_q       <= lane_d;
            fp_q         <= fp_d;
            word_q       <= word_d;
            word_last_q  <= word_last_d;
            lane_last_q  <= lane_last_d;
            group_last_q <= group_last_d;
        end
    end

    // Operand outputs straight from flops.
    always_comb begin
        out_fp_o         = fp_q;
        out_int_o        = word_q[INT_WIDTH-1:0];
        out_lane_last_o  = lane_last_q;
        out_group_last_o = group_last_q;
    end

`ifdef FP_INT_FEEDER_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Count cycles where a pair is offered but not taken; saturate at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid_o && !out_ready_i && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: doc/fp_int_operand_feeder.md
Name: fp_int_operand_feeder

Overview:
- Upstream feeder for the combinational FP×INT multiplier.
- Accepts one packed word per transfer: LANES signed integers plus a single shared FP scale operand.
- Serialises the word into one (fp, int) operand pair per cycle over a valid/ready stream.
- Its outputs drive the multiplier's operand_a_i (FP) and operand_b_i (INT) directly from registers, so the multiplier's inputs are glitch-free and timing-isolated.

Parameters:
- FP_WIDTH, 16, width of the shared FP operand (FP16 encoding, passed through untouched)
- INT_WIDTH, 4, width of each signed integer lane
- LANES, 8, integer lanes per packed input word (≥2)

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- in_valid_i  in  1  input word valid
- in_ready_o  out  1  feeder can accept a word this cycle
- in_fp_i  in  FP_WIDTH  shared FP operand for the word
- in_int_i  in  LANES*INT_WIDTH  packed integers; lane k = bits [k*INT_WIDTH +: INT_WIDTH]
- in_last_i  in  1  word is the final word of a group
- out_valid_o  out  1  operand pair valid
- out_ready_i  in  1  downstream accepts pair
- out_fp_o  out  FP_WIDTH  FP operand (to multiplier operand_a_i)
- out_int_o  out  INT_WIDTH  current integer lane (to multiplier operand_b_i)
- out_lane_last_o  out  1  pair is lane LANES-1 of its word
- out_group_last_o  out  1  out_lane_last_o AND the word's in_last_i
- busy_o  out  1  a word is held (state STREAM)

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is asynchronous and active-high.
- Reset values:
  - state = IDLE, lane counter = 0.
  - out_valid_o = 0, busy_o = 0.
  - out_fp_o, out_int_o, out_lane_last_o, out_group_last_o all 0.
- State IDLE:
  - in_ready_o = 1.
  - On in_valid_i: capture in_fp_i, in_int_i and in_last_i into registers; lane = 0; go to STREAM.
- State STREAM:
  - out_valid_o = 1.
  - out_int_o = lane `lane` of the captured word; out_fp_o = captured FP value.
- Advance rule: an output transfer (out_valid_o & out_ready_i) with lane < LANES-1 increments lane. Nothing else advances the lane.
- Last-lane transfer: an output transfer at lane = LANES-1 either
  - captures a new word if in_valid_i (lane = 0, stay in STREAM), or
  - goes to IDLE otherwise.
- in_ready_o in STREAM = out_ready_i & (lane == LANES-1). This is a combinational path from out_ready_i and gives zero-bubble back-to-back words.
- Latency: word accepted on edge t → lane 0 on outputs after edge t; sustained throughput is 1 lane/cycle.
- Backpressure: while out_valid_o & !out_ready_i, every output holds bit-stable.
- Integer lanes are not sign-extended or modified; signed interpretation belongs downstream.
- Reset asserted mid-word: the word is dropped, outputs return to reset values immediately, and no partial lanes are emitted after release.
- in_valid_i is ignored when in_ready_o = 0; the source must hold its data until the handshake completes.

Optional Feature:
- Macro: FP_INT_FEEDER_PERF_CNT_EN.
- With the macro defined:
  - Adds output stall_cnt_o, 32 bits.
  - Increments on every cycle with out_valid_o & !out_ready_i.
  - Saturates at 0xFFFF_FFFF.
  - Cleared by rst_i.
- Without the macro: the port and counter are absent; the rest of the behaviour is identical.

Test Plan:
- Single word, no backpressure:
  - Stimulus: in_fp_i=16'h3C00, in_int_i=32'h8765_4321, in_last_i=1, out_ready_i=1.
  - Response: out_int_o sequence 1,2,3,4,5,6,7,8 on 8 consecutive cycles; out_fp_o=16'h3C00 throughout.
  - Only the 8th pair has out_lane_last_o=1 and out_group_last_o=1; then out_valid_o=0.
- Back-to-back words:
  - Stimulus: words 32'h7777_7777 and 32'hFFFF_FFFF (in_last_i=0 then 1), in_valid_i held high.
  - Response: 16 contiguous valid cycles, no bubble; in_ready_o high only in cycles 0 (IDLE), 8 and 16.
- Backpressure:
  - Stimulus: out_ready_i low for 3 cycles at lane 2.
  - Response: out_int_o, out_fp_o and flags stable for those 3 cycles; lane 3 appears the cycle after out_ready_i rises.
  - With FP_INT_FEEDER_PERF_CNT_EN: stall_cnt_o increases by 3.
- Async reset mid-stream:
  - Stimulus: assert rst_i between edges at lane 5.
  - Response: out_valid_o=0 without waiting for an edge; after release in_ready_o=1 and state is IDLE.
  - Next word starts at lane 0.
- Idle hold:
  - Stimulus: in_valid_i=0 for 10 cycles after reset.
  - Response: out_valid_o=0, busy_o=0, in_ready_o=1 throughout.
